// File: rtl/spart_pkg.sv
// Shared SPART definitions: I/O register map, baud-generator state encoding
// and the power-on divisor.
package spart_pkg;

  localparam logic [1:0] ADDR_TXRX   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } brg_state_e;

  // 50 MHz clock, 19200 baud, x16 oversampling
  localparam logic [15:0] DEFAULT_DIVISOR = 16'd162;

endpackage

// File: rtl/brg_downcounter.sv
// Loadable down-counter for the baud generator; saturates at zero and flags it.
module brg_downcounter #(
  parameter int           W           = 16,
  parameter logic [W-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spart_baud_gen.sv
// SPART baud-rate generator: byte-wise divisor programming and a one-cycle
// brg_en tick every divisor+1 clocks once a divisor has been committed.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter int                DIV_W         = 16,
  parameter logic [DIV_W-1:0]  RESET_DIVISOR = DEFAULT_DIVISOR,
  parameter bit                AUTO_START    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iocs,
  input  logic              iorw,
  input  logic [1:0]        ioaddr,
  input  logic [DATA_W-1:0] databus_in,
  output logic              brg_en,
  output logic              running,
  output logic [DIV_W-1:0]  divisor
);

  brg_state_e        state;
  brg_state_e        state_next;
  logic [DATA_W-1:0] staged_low;
  logic [DIV_W-1:0]  new_div;
  logic [DIV_W-1:0]  load_value;
  logic              wr_lo;
  logic              wr_hi;
  logic              cnt_load;
  logic              cnt_zero;

  assign wr_lo   = iocs && !iorw && (ioaddr == ADDR_DB_LO);
  assign wr_hi   = iocs && !iorw && (ioaddr == ADDR_DB_HI);
  assign new_div = {databus_in, staged_low};
  assign running = (state == RUN);

  // A high-byte write is the commit: it reloads the counter and wins over reload-at-zero.
  assign cnt_load   = wr_hi || (running && cnt_zero);
  assign load_value = wr_hi ? new_div : divisor;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (wr_hi)      state_next = RUN;
        else if (wr_lo) state_next = ARMED;
      end
      ARMED: begin
        if (wr_hi) state_next = RUN;
      end
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (AUTO_START) state <= RUN;
      else            state <= IDLE;
      divisor    <= RESET_DIVISOR;
      staged_low <= '0;
      brg_en     <= 1'b0;
    end else begin
      state  <= state_next;
      brg_en <= running && cnt_zero && !wr_hi;
      if (wr_lo) staged_low <= databus_in;
      if (wr_hi) divisor    <= new_div;
    end
  end

  brg_downcounter #(
    .W           (DIV_W),
    .RESET_VALUE (RESET_DIVISOR)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .en         (running),
    .load_value (load_value),
    .zero       (cnt_zero)
  );

endmodule
